menu_uart_tx: RTL and testbench

- Downstream consumer of the menu block's encoded selection (`arduino_out`) and page select (`menu_sel`).
- Serialises every change of {page, value} into one 8N1 UART byte on a single TX line, which drives the Arduino display board.
- Sends only on change or on explicit request, so the Arduino always holds the latest menu cursor without continuous traffic.

---
 rtl/menu_uart_tx_if.sv | 33 +++
 rtl/menu_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_menu_uart_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/menu_uart_tx_if.sv
// Handshake bundle between the menu block and the UART frame transmitter:
// page/value selection and send controls in, serial line and status out.
interface menu_uart_tx_if #(
    parameter int VALUE_W = 4
);
    logic               enable;
    logic [1:0]         menu_sel;
    logic [VALUE_W-1:0] value;
    logic               force_send;
    logic               tx;
    logic               busy;
    logic               done;

    modport master (
        output enable,
        output menu_sel,
        output value,
        output force_send,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  menu_sel,
        input  value,
        input  force_send,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/menu_uart_tx.sv
// Sends {2'b10, menu_sel, value} as one 8N1 UART byte whenever the selection
// changes or a resend is requested; changes seen mid-frame coalesce into one follow-up.
module menu_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int VALUE_W      = 4
) (
    input  logic            clock,
    input  logic            reset,
    menu_uart_tx_if.slave   bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IN_W  = VALUE_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_idx;
    logic [7:0]        r_byte;
    logic [IN_W-1:0]   r_last_sent;
    logic              r_last_valid;
    logic              r_pending;
    logic [IN_W-1:0]   r_in_prev;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_idx_nxt;
    logic [7:0]        w_byte_nxt;
    logic [IN_W-1:0]   w_last_sent_nxt;
    logic              w_last_valid_nxt;
    logic              w_pending_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic [IN_W-1:0]   w_in;
    logic              w_trigger;
    logic              w_cnt_done;

    assign w_in       = {bus.menu_sel, bus.value};
    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_trigger  = bus.enable & (r_pending | bus.force_send |
                                      (w_in != r_last_sent) | ~r_last_valid);

    // State and datapath registers; outputs are registered from next-state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_idx        <= 3'd0;
            r_byte       <= 8'hFF;
            r_last_sent  <= {IN_W{1'b0}};
            r_last_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_in_prev    <= {IN_W{1'b0}};
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_byte       <= w_byte_nxt;
            r_last_sent  <= w_last_sent_nxt;
            r_last_valid <= w_last_valid_nxt;
            r_pending    <= w_pending_nxt;
            r_in_prev    <= w_in;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state, bit timing and change tracking.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_byte_nxt       = r_byte;
        w_last_sent_nxt  = r_last_sent;
        w_last_valid_nxt = r_last_valid;
        w_pending_nxt    = r_pending;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                w_idx_nxt = 3'd0;
                if (w_trigger) begin
                    w_state_nxt      = ST_START;
                    w_byte_nxt       = {2'b10, w_in};
                    w_last_sent_nxt  = w_in;
                    w_last_valid_nxt = 1'b1;
                    w_pending_nxt    = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_idx_nxt   = 3'd0;
            end
        endcase

        // Anything that moves while a frame is on the wire earns one follow-up frame.
        if ((r_state != ST_IDLE) && (bus.force_send || (w_in != r_in_prev))) begin
            w_pending_nxt = 1'b1;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
    end

    // Line level and status decoded from where the FSM will be next cycle.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
        case (w_state_nxt)
            ST_IDLE:  w_tx_nxt = 1'b1;
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_byte_nxt[w_idx_nxt];
            ST_STOP:  w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_menu_uart_tx.sv
// Randomised and directed bench for menu_uart_tx, checked cycle by cycle against
// a frame-timeline model plus an independent UART byte decoder on the tx line.
module tb_menu_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    menu_uart_tx_if #(.VALUE_W(4)) bus ();

    menu_uart_tx #(.CLKS_PER_BIT(CPB), .VALUE_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit         m_active = 1'b0;
    int         m_e = 0;
    logic [7:0] m_byte = 8'h00;
    logic [5:0] m_last = 6'd0;
    bit         m_lv = 1'b0;
    bit         m_pend = 1'b0;
    logic [5:0] m_prev = 6'd0;
    logic       m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    int         m_done_total = 0;

    int         rx_cnt = -1;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    int         done_cnt = 0, done_total = 0, busy_cyc = 0;

    bit         t_en = 1'b0;
    logic [1:0] t_sel = 2'd0;
    logic [3:0] t_val = 4'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timeline model: a frame triggered at edge e is visible after edges e..e+FRAME-1.
    task automatic model_edge(input bit rst, input bit en, input logic [5:0] in, input bit fs);
        bit busy_before;
        int off;
        int b;
        cyc++;
        if (rst) begin
            m_active = 1'b0; m_pend = 1'b0; m_lv = 1'b0;
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            busy_before = m_active && (cyc <= m_e + FRAME);
            m_done = m_active && (cyc == m_e + FRAME);
            if (busy_before) begin
                if (fs || (in != m_prev)) m_pend = 1'b1;
            end else if (en && (m_pend || fs || (in != m_last) || !m_lv)) begin
                m_e = cyc; m_byte = {2'b10, in}; m_last = in;
                m_lv = 1'b1; m_pend = 1'b0; m_active = 1'b1;
            end
            if (m_active && (cyc >= m_e) && (cyc <= m_e + FRAME - 1)) begin
                off = cyc - m_e;
                b = off / CPB;
                m_busy = 1'b1;
                if (b == 0)      m_tx = 1'b0;
                else if (b == 9) m_tx = 1'b1;
                else             m_tx = m_byte[b-1];
            end else begin
                m_tx = 1'b1; m_busy = 1'b0;
            end
        end
        m_prev = in;
        if (m_done) m_done_total++;
    endtask

    task automatic cycle(input bit rst, input bit en, input logic [1:0] sel,
                         input logic [3:0] val, input bit fs);
        int b;
        reset = rst; bus.enable = en; bus.menu_sel = sel; bus.value = val; bus.force_send = fs;
        @(posedge clock);
        model_edge(rst, en, {sel, val}, fs);
        @(negedge clock);
        check_val($sformatf("tx@%0d", cyc), bus.tx, m_tx);
        check_val($sformatf("busy@%0d", cyc), bus.busy, m_busy);
        check_val($sformatf("done@%0d", cyc), bus.done, m_done);
        if (bus.done === 1'b1) begin done_cnt++; done_total++; end
        if (bus.busy === 1'b1) busy_cyc++;
        // Independent receiver: mid-bit sampling from the first low cycle.
        if (rst) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (bus.tx === 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            b = rx_cnt / CPB;
            if ((rx_cnt % CPB == CPB / 2) && (b >= 1) && (b <= 8)) rx_sh[b-1] = bus.tx;
            if (rx_cnt == 9 * CPB + CPB / 2) rx_q.push_back(rx_sh);
            if (rx_cnt == FRAME - 1) rx_cnt = -1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, t_en, t_sel, t_val, 1'b0);
    endtask

    task automatic pulse_force();
        cycle(1'b0, t_en, t_sel, t_val, 1'b1);
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b0; bus.menu_sel = 2'd0; bus.value = 4'd0; bus.force_send = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);

        // First frame 0xB5
        t_en = 1'b1; t_sel = 2'd3; t_val = 4'd5;
        busy_cyc = 0; done_cnt = 0;
        run(45);
        check_val("rx_n_first", rx_q.size(), 1);
        check_val("rx_first", rx_q[0], 8'hB5);
        check_val("busy_len", busy_cyc, 40);
        check_val("done_once", done_cnt, 1);

        // Stable inputs: silence
        done_cnt = 0; busy_cyc = 0;
        run(200);
        check_val("quiet_done", done_cnt, 0);
        check_val("quiet_busy", busy_cyc, 0);
        check_val("quiet_rx_n", rx_q.size(), 1);

        // Coalesced changes during a resent frame
        pulse_force();
        run(10); t_val = 4'd6;
        run(5);  t_val = 4'd7;
        run(100);
        check_val("coal_rx_n", rx_q.size(), 3);
        check_val("coal_resend", rx_q[1], 8'hB5);
        check_val("coal_follow", rx_q[2], 8'hB7);

        // force_send from idle and while busy
        t_sel = 2'd1; t_val = 4'd2;
        run(50);
        pulse_force(); run(10); pulse_force(); run(100);
        check_val("force_rx_n", rx_q.size(), 6);
        check_val("force_chg", rx_q[3], 8'h92);
        check_val("force_idle", rx_q[4], 8'h92);
        check_val("force_busy", rx_q[5], 8'h92);

        // Reset mid-frame, then fresh frame 0x81
        t_sel = 2'd2; t_val = 4'd9;
        run(15);
        cycle(1'b1, 1'b1, 2'd0, 4'd1, 1'b0);
        check_val("rst_tx", bus.tx, 1);
        check_val("rst_busy", bus.busy, 0);
        t_sel = 2'd0; t_val = 4'd1;
        run(50);
        check_val("rst_rx_n", rx_q.size(), 7);
        check_val("rst_fresh", rx_q[6], 8'h81);

        // Reset while disabled, change inputs, then enable
        cycle(1'b1, 1'b0, 2'd0, 4'd1, 1'b0);
        t_en = 1'b0; t_sel = 2'd2; t_val = 4'd3;
        run(100);
        check_val("dis_rx_n", rx_q.size(), 7);
        t_en = 1'b1;
        run(150);
        check_val("en_rx_n", rx_q.size(), 8);
        check_val("en_frame", rx_q[7], 8'hA3);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 4) begin
                t_sel = 2'($urandom_range(3));
                t_val = 4'($urandom_range(15));
            end
            if ($urandom_range(99) < 2) t_en = ~t_en;
            cycle(($urandom_range(999) < 3), t_en, t_sel, t_val, ($urandom_range(99) < 3));
        end
        run(60);
        check_val("done_total", done_total, m_done_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
